systolic_sequencer: RTL and testbench

Instruction-driven controller that runs the N×N systolic MAC array inside top.
- After ap_start, fetches 4-bit instructions from the 8-entry instruction memory.
- Each nonzero instruction K is one tile: stream pre-skewed A/B columns from memA/memB, then write the N*N 32-bit results to output memory.
- Instruction 0, or reaching the end of instruction memory, ends the program and raises ap_done.

---
 rtl/systolic_sequencer_pkg.sv | 34 +++
 rtl/systolic_sequencer_if.sv | 42 ++++
 rtl/systolic_sequencer_addr_gen.sv | 139 +++++++++++++
 rtl/systolic_sequencer.sv | 156 +++++++++++++++
 tb/tb_systolic_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// systolic_sequencer_pkg
// Shared constants, FSM state encoding and the tile stride helper used by the
// systolic array sequencer, its address generator and its bus interface.
// -----------------------------------------------------------------------------
package systolic_sequencer_pkg;

    localparam int unsigned N        = 4;             // array dimension
    localparam int unsigned K_W      = 4;             // instruction width
    localparam int unsigned IADDR_W  = 3;             // instruction memory address width
    localparam int unsigned COL_W    = 8;             // memA/memB column index width
    localparam int unsigned OADDR_W  = 7;             // output memory address width
    localparam int unsigned SEL_W    = $clog2(N * N); // PE result select width
    localparam int unsigned STRIDE_W = K_W + 1;       // holds K + 2N - 1

    localparam logic [K_W-1:0] HALT_OP = {K_W{1'b0}};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        CLEAR     = 3'd3,
        STREAM    = 3'd4,
        FLUSH     = 3'd5,
        WRITEBACK = 3'd6,
        DONE      = 3'd7
    } state_t;

    // Columns consumed by one tile: K data columns plus 2N-1 skew/drain columns.
    function automatic logic [STRIDE_W-1:0] stride(input logic [K_W-1:0] k);
        return STRIDE_W'(k) + STRIDE_W'(2 * N - 1);
    endfunction

endpackage

// File: rtl/systolic_sequencer_if.sv
// -----------------------------------------------------------------------------
// systolic_sequencer_if
// Control handshake plus instruction/operand/result memory bus of the
// sequencer.  master = sequencer side, slave = memories / host side.
//   ap_start, ap_done, currInstruction : host handshake
//   addrI, rdI, dataI                   : instruction memory (1-cycle read)
//   rd_col, rd_en                       : memA/memB column read
//   arr_clear, arr_en, out_sel          : systolic array control
//   wrO, addrO                          : output memory write
// -----------------------------------------------------------------------------
interface systolic_sequencer_if #(
    parameter int unsigned COLW = systolic_sequencer_pkg::COL_W
);
    import systolic_sequencer_pkg::*;

    logic                 ap_start;
    logic                 ap_done;
    logic [IADDR_W-1:0]   addrI;
    logic                 rdI;
    logic [K_W-1:0]       dataI;
    logic [COLW-1:0]      rd_col;
    logic                 rd_en;
    logic                 arr_clear;
    logic                 arr_en;
    logic [SEL_W-1:0]     out_sel;
    logic                 wrO;
    logic [OADDR_W-1:0]   addrO;
    logic [K_W-1:0]       currInstruction;

    modport master (
        input  ap_start, dataI,
        output ap_done, addrI, rdI, rd_col, rd_en, arr_clear, arr_en,
               out_sel, wrO, addrO, currInstruction
    );

    modport slave (
        output ap_start, dataI,
        input  ap_done, addrI, rdI, rd_col, rd_en, arr_clear, arr_en,
               out_sel, wrO, addrO, currInstruction
    );

endinterface

// File: rtl/systolic_sequencer_addr_gen.sv
// -----------------------------------------------------------------------------
// seq_addr_gen
// Owns the per-program column base and output base pointers plus the stream
// (c) and writeback (k) counters.  All address outputs are registered so they
// line up with the FSM's registered enables.
//   clk, rst    : clock, async active-high reset
//   state_i     : current sequencer state
//   start_i     : accepted ap_start, clears base/ob
//   k_i         : instruction of the executing tile
//   dec_k_i     : instruction being decoded (for the fit check)
//   rd_col_o    : memA/memB column index (base + c)
//   out_sel_o   : PE result select (k)
//   addr_o_o    : output memory address (ob + k)
//   c_last_o    : last STREAM cycle
//   k_last_o    : last WRITEBACK cycle
//   fits_o      : decoded tile stays inside the column space
// -----------------------------------------------------------------------------
module seq_addr_gen
    import systolic_sequencer_pkg::*;
#(
    parameter int unsigned COLW = COL_W
) (
    input  logic                clk,
    input  logic                rst,
    input  state_t              state_i,
    input  logic                start_i,
    input  logic [K_W-1:0]      k_i,
    input  logic [K_W-1:0]      dec_k_i,
    output logic [COLW-1:0]     rd_col_o,
    output logic [SEL_W-1:0]    out_sel_o,
    output logic [OADDR_W-1:0]  addr_o_o,
    output logic                c_last_o,
    output logic                k_last_o,
    output logic                fits_o
);

    // base needs one extra bit: it may legally land exactly on 2^COLW.
    localparam int unsigned BASE_W  = COLW + 1;
    localparam int unsigned SUM_W   = COLW + 2;
    localparam int unsigned COL_CNT = 1 << COLW;

    logic [BASE_W-1:0]   base_q,    base_d;
    logic [OADDR_W-1:0]  ob_q,      ob_d;
    logic [STRIDE_W-1:0] c_q,       c_d;
    logic [COLW-1:0]     rd_col_q,  rd_col_d;
    logic [SEL_W-1:0]    out_sel_q, out_sel_d;
    logic [OADDR_W-1:0]  addr_o_q,  addr_o_d;
    logic                c_last_s;
    logic                k_last_s;
    logic [SUM_W-1:0]    end_col_s;

    assign c_last_s  = (c_q == (stride(k_i) - STRIDE_W'(1)));
    assign k_last_s  = (out_sel_q == SEL_W'(N * N - 1));
    assign end_col_s = SUM_W'(base_q) + SUM_W'(stride(dec_k_i));

    // Program pointers: cleared on start, advanced once per finished tile.
    always_comb begin
        base_d = base_q;
        ob_d   = ob_q;
        if (start_i) begin
            base_d = {BASE_W{1'b0}};
            ob_d   = {OADDR_W{1'b0}};
        end else if ((state_i == WRITEBACK) && k_last_s) begin
            base_d = base_q + BASE_W'(stride(k_i));
            ob_d   = ob_q + OADDR_W'(N * N);
        end else begin
            base_d = base_q;
            ob_d   = ob_q;
        end
    end

    // Counters and registered addresses; the load happens in the state before
    // the phase so the first active cycle already shows base / ob.
    always_comb begin
        c_d       = {STRIDE_W{1'b0}};
        rd_col_d  = {COLW{1'b0}};
        out_sel_d = {SEL_W{1'b0}};
        addr_o_d  = {OADDR_W{1'b0}};
        case (state_i)
            CLEAR: begin
                rd_col_d = base_q[COLW-1:0];
            end
            STREAM: begin
                if (!c_last_s) begin
                    c_d      = c_q + STRIDE_W'(1);
                    rd_col_d = rd_col_q + COLW'(1);
                end else begin
                    c_d      = {STRIDE_W{1'b0}};
                    rd_col_d = {COLW{1'b0}};
                end
            end
            FLUSH: begin
                addr_o_d = ob_q;
            end
            WRITEBACK: begin
                if (!k_last_s) begin
                    out_sel_d = out_sel_q + SEL_W'(1);
                    addr_o_d  = addr_o_q + OADDR_W'(1);
                end else begin
                    out_sel_d = {SEL_W{1'b0}};
                    addr_o_d  = {OADDR_W{1'b0}};
                end
            end
            default: begin
                c_d       = {STRIDE_W{1'b0}};
                rd_col_d  = {COLW{1'b0}};
                out_sel_d = {SEL_W{1'b0}};
                addr_o_d  = {OADDR_W{1'b0}};
            end
        endcase
    end

    // State registers of the address generator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q    <= {BASE_W{1'b0}};
            ob_q      <= {OADDR_W{1'b0}};
            c_q       <= {STRIDE_W{1'b0}};
            rd_col_q  <= {COLW{1'b0}};
            out_sel_q <= {SEL_W{1'b0}};
            addr_o_q  <= {OADDR_W{1'b0}};
        end else begin
            base_q    <= base_d;
            ob_q      <= ob_d;
            c_q       <= c_d;
            rd_col_q  <= rd_col_d;
            out_sel_q <= out_sel_d;
            addr_o_q  <= addr_o_d;
        end
    end

    assign rd_col_o  = rd_col_q;
    assign out_sel_o = out_sel_q;
    assign addr_o_o  = addr_o_q;
    assign c_last_o  = c_last_s;
    assign k_last_o  = k_last_s;
    assign fits_o    = (end_col_s <= SUM_W'(COL_CNT));

endmodule

// File: rtl/systolic_sequencer.sv
// -----------------------------------------------------------------------------
// systolic_sequencer
// Instruction-driven controller for the NxN systolic MAC array.  After
// ap_start it fetches instructions; each nonzero K runs one tile
// (CLEAR, STREAM K+2N-1 columns, FLUSH, WRITEBACK N*N results).  Instruction 0
// or the end of instruction memory ends the program and raises ap_done.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : systolic_sequencer_if.master (handshake + memory/array bus)
// -----------------------------------------------------------------------------
module systolic_sequencer
    import systolic_sequencer_pkg::*;
#(
    parameter int unsigned COLW = COL_W
) (
    input  logic                       clk,
    input  logic                       rst,
    systolic_sequencer_if.master       bus
);

    state_t             state_q;
    logic [IADDR_W-1:0] pc_q;
    logic [IADDR_W-1:0] addr_i_q;
    logic               rd_i_q;
    logic               arr_clear_q;
    logic               rd_en_q;
    logic               arr_en_q;
    logic               wr_o_q;
    logic               ap_done_q;
    logic [K_W-1:0]     cur_q;

    logic               start_s;
    logic               c_last_s;
    logic               k_last_s;
    logic               fits_s;
    logic [COLW-1:0]    rd_col_s;
    logic [SEL_W-1:0]   out_sel_s;
    logic [OADDR_W-1:0] addr_o_s;

    // ap_start is only honoured while waiting (IDLE) or finished (DONE).
    assign start_s = bus.ap_start && ((state_q == IDLE) || (state_q == DONE));

    seq_addr_gen #(
        .COLW      (COLW)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .state_i   (state_q),
        .start_i   (start_s),
        .k_i       (cur_q),
        .dec_k_i   (bus.dataI),
        .rd_col_o  (rd_col_s),
        .out_sel_o (out_sel_s),
        .addr_o_o  (addr_o_s),
        .c_last_o  (c_last_s),
        .k_last_o  (k_last_s),
        .fits_o    (fits_s)
    );

    // Sequencer FSM; every output is registered and set on entry to the state
    // that owns it, so one-cycle strobes default back to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= {IADDR_W{1'b0}};
            addr_i_q    <= {IADDR_W{1'b0}};
            rd_i_q      <= 1'b0;
            arr_clear_q <= 1'b0;
            rd_en_q     <= 1'b0;
            arr_en_q    <= 1'b0;
            wr_o_q      <= 1'b0;
            ap_done_q   <= 1'b0;
            cur_q       <= {K_W{1'b0}};
        end else begin
            addr_i_q    <= {IADDR_W{1'b0}};
            rd_i_q      <= 1'b0;
            arr_clear_q <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_o_q      <= 1'b0;
            // arr_en trails rd_en by one cycle so the last read still shifts in.
            arr_en_q    <= (state_q == CLEAR) ? 1'b0 : rd_en_q;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.ap_start) begin
                        state_q   <= FETCH;
                        pc_q      <= {IADDR_W{1'b0}};
                        rd_i_q    <= 1'b1;
                        ap_done_q <= 1'b0;
                    end
                end
                FETCH: begin
                    state_q <= DECODE;
                end
                DECODE: begin
                    if ((bus.dataI == HALT_OP) || !fits_s) begin
                        state_q   <= DONE;
                        ap_done_q <= 1'b1;
                        cur_q     <= {K_W{1'b0}};
                    end else begin
                        state_q     <= CLEAR;
                        cur_q       <= bus.dataI;
                        arr_clear_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    state_q <= STREAM;
                    rd_en_q <= 1'b1;
                end
                STREAM: begin
                    if (c_last_s) begin
                        state_q <= FLUSH;
                    end else begin
                        rd_en_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    state_q <= WRITEBACK;
                    wr_o_q  <= 1'b1;
                end
                WRITEBACK: begin
                    if (k_last_s) begin
                        pc_q <= pc_q + IADDR_W'(1);
                        // pc about to wrap: every instruction slot has run.
                        if (pc_q == {IADDR_W{1'b1}}) begin
                            state_q   <= DONE;
                            ap_done_q <= 1'b1;
                            cur_q     <= {K_W{1'b0}};
                        end else begin
                            state_q  <= FETCH;
                            rd_i_q   <= 1'b1;
                            addr_i_q <= pc_q + IADDR_W'(1);
                        end
                    end else begin
                        wr_o_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ap_done         = ap_done_q;
    assign bus.addrI           = addr_i_q;
    assign bus.rdI             = rd_i_q;
    assign bus.rd_col          = rd_col_s;
    assign bus.rd_en           = rd_en_q;
    assign bus.arr_clear       = arr_clear_q;
    assign bus.arr_en          = arr_en_q;
    assign bus.out_sel         = out_sel_s;
    assign bus.wrO             = wr_o_q;
    assign bus.addrO           = addr_o_s;
    assign bus.currInstruction = cur_q;

endmodule

// File: tb/tb_systolic_sequencer.sv
// -----------------------------------------------------------------------------
// tb_systolic_sequencer
// Directed bench for systolic_sequencer.  A second instance with a 32-column
// operand space exercises the tile-does-not-fit path.
// -----------------------------------------------------------------------------
module tb_systolic_sequencer;

    logic clk;
    logic rst;
    logic go;
    logic sel2;
    logic [3:0] imem [8];

    int n_vec;
    int n_err;

    systolic_sequencer_if #(.COLW(8)) bus  ();
    systolic_sequencer_if #(.COLW(5)) bus2 ();

    systolic_sequencer #(.COLW(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
    systolic_sequencer #(.COLW(5)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    assign bus.ap_start  = go & ~sel2;
    assign bus2.ap_start = go & sel2;

    always #5 clk = ~clk;

    // instruction memories: 1-cycle read latency
    always @(posedge clk) begin
        if (bus.rdI) bus.dataI <= imem[bus.addrI];
    end
    always @(posedge clk) begin
        if (bus2.rdI) bus2.dataI <= imem[bus2.addrI];
    end

    // observed signals of the instance under test
    logic       mon_wrO, mon_rd_en, mon_arr_en, mon_clear, mon_rdI, mon_done;
    logic [7:0] mon_col;
    logic [6:0] mon_addrO;
    logic [3:0] mon_sel, mon_cur;
    logic [31:0] outs;

    assign mon_wrO    = sel2 ? bus2.wrO       : bus.wrO;
    assign mon_rd_en  = sel2 ? bus2.rd_en     : bus.rd_en;
    assign mon_arr_en = sel2 ? bus2.arr_en    : bus.arr_en;
    assign mon_clear  = sel2 ? bus2.arr_clear : bus.arr_clear;
    assign mon_rdI    = sel2 ? bus2.rdI       : bus.rdI;
    assign mon_done   = sel2 ? bus2.ap_done   : bus.ap_done;
    assign mon_col    = sel2 ? {3'b000, bus2.rd_col} : bus.rd_col;
    assign mon_addrO  = sel2 ? bus2.addrO     : bus.addrO;
    assign mon_sel    = sel2 ? bus2.out_sel   : bus.out_sel;
    assign mon_cur    = sel2 ? bus2.currInstruction : bus.currInstruction;

    assign outs = {bus.ap_done, bus.addrI, bus.rdI, bus.rd_col, bus.rd_en,
                   bus.arr_clear, bus.arr_en, bus.out_sel, bus.wrO, bus.addrO,
                   bus.currInstruction};

    int   wr_q[$];
    int   bases_q[$];
    int   curs_q[$];
    int   rd_cnt, clr_cnt, fetch_cnt, sel_bad, en_bad, col_bad;
    logic prev_rd_en;
    logic [7:0] prev_col;

    // activity monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (mon_wrO) begin
            wr_q.push_back(int'(mon_addrO));
            if (mon_sel != mon_addrO[3:0]) sel_bad <= sel_bad + 1;
        end
        if (mon_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (!prev_rd_en) begin
                bases_q.push_back(int'(mon_col));
                curs_q.push_back(int'(mon_cur));
            end else if (mon_col != prev_col + 8'd1) begin
                col_bad <= col_bad + 1;
            end
        end
        if (mon_arr_en != prev_rd_en) en_bad <= en_bad + 1;
        if (mon_clear) clr_cnt <= clr_cnt + 1;
        if (mon_rdI) fetch_cnt <= fetch_cnt + 1;
        prev_rd_en <= mon_rd_en;
        prev_col   <= mon_col;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input logic [3:0] p [8]);
        for (int i = 0; i < 8; i++) imem[i] = p[i];
    endtask

    task automatic clear_mon();
        wr_q.delete();
        bases_q.delete();
        curs_q.delete();
        rd_cnt = 0; clr_cnt = 0; fetch_cnt = 0;
        sel_bad = 0; en_bad = 0; col_bad = 0;
        prev_rd_en = 1'b0;
    endtask

    // one-cycle ap_start, then count rising edges until ap_done
    task automatic run(input string tag, input bit pulse_wb, output int cycles);
        bit pulsed;
        pulsed = 1'b0;
        @(negedge clk); #1;
        clear_mon();
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        check({tag, ".done_low"}, mon_done, 1'b0);
        cycles = 0;
        while (!mon_done && cycles < 3000) begin
            @(posedge clk); #1;
            cycles++;
            if (pulse_wb && !pulsed && mon_wrO) begin
                go = 1'b1;
                pulsed = 1'b1;
            end else begin
                go = 1'b0;
            end
        end
        go = 1'b0;
        check({tag, ".no_timeout"}, cycles < 3000, 1'b1);
    endtask

    task automatic check_run(input string tag, input int cyc, input int exp_cyc,
                             input int ntile, input int eb [8], input int ec [8],
                             input int exp_wr, input int exp_fetch, input int exp_rd);
        int bad;
        check({tag, ".cycles"}, cyc, exp_cyc);
        check({tag, ".ap_done"}, mon_done, 1'b1);
        check({tag, ".cur_idle"}, mon_cur, 4'd0);
        check({tag, ".tiles"}, bases_q.size(), ntile);
        check({tag, ".clears"}, clr_cnt, ntile);
        for (int i = 0; i < ntile && i < bases_q.size(); i++) begin
            check($sformatf("%s.base%0d", tag, i), bases_q[i], eb[i]);
            check($sformatf("%s.instr%0d", tag, i), curs_q[i], ec[i]);
        end
        check({tag, ".writes"}, wr_q.size(), exp_wr);
        bad = 0;
        foreach (wr_q[i]) if (wr_q[i] != i) bad++;
        check({tag, ".wr_order"}, bad, 0);
        if (wr_q.size() > 0) check({tag, ".last_addrO"}, wr_q[$], exp_wr - 1);
        check({tag, ".fetches"}, fetch_cnt, exp_fetch);
        check({tag, ".reads"}, rd_cnt, exp_rd);
        check({tag, ".out_sel"}, sel_bad, 0);
        check({tag, ".arr_en"}, en_bad, 0);
        check({tag, ".rd_col_seq"}, col_bad, 0);
    endtask

    initial begin
        int cyc;
        int n;
        n_vec = 0; n_err = 0;
        clk = 1'b0; rst = 1'b1; go = 1'b0; sel2 = 1'b0;
        for (int i = 0; i < 8; i++) imem[i] = 4'd0;
        clear_mon();
        repeat (3) @(negedge clk);
        check("reset.outs", outs, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle.outs", outs, 32'd0);

        // mixed program ending on HALT
        load('{4'd5, 4'd4, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0, 4'd0});
        run("prog1", 1'b0, cyc);
        check_run("prog1", cyc, 152, 5, '{0, 12, 23, 31, 40, 0, 0, 0},
                  '{5, 4, 1, 2, 3, 0, 0, 0}, 80, 6, 50);

        // restart from DONE with an immediate HALT
        load('{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0});
        run("halt", 1'b0, cyc);
        check_run("halt", cyc, 2, 0, '{0, 0, 0, 0, 0, 0, 0, 0},
                  '{0, 0, 0, 0, 0, 0, 0, 0}, 0, 1, 0);

        // all slots K=1: memory end terminates after 8 tiles
        load('{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1});
        run("ones", 1'b0, cyc);
        check_run("ones", cyc, 224, 8, '{0, 8, 16, 24, 32, 40, 48, 56},
                  '{1, 1, 1, 1, 1, 1, 1, 1}, 128, 8, 64);

        // all slots K=15: base steps by 22
        load('{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15});
        run("max", 1'b0, cyc);
        check_run("max", cyc, 336, 8, '{0, 22, 44, 66, 88, 110, 132, 154},
                  '{15, 15, 15, 15, 15, 15, 15, 15}, 128, 8, 176);

        // ap_start during WRITEBACK has no effect
        load('{4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0});
        run("wb_start", 1'b1, cyc);
        check_run("wb_start", cyc, 31, 1, '{0, 0, 0, 0, 0, 0, 0, 0},
                  '{2, 0, 0, 0, 0, 0, 0, 0}, 16, 2, 9);

        // reset in the middle of tile 2 streaming, then a clean rerun
        load('{4'd5, 4'd4, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0, 4'd0});
        @(negedge clk); #1;
        clear_mon();
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        n = 0;
        while (!(clr_cnt == 2 && bus.rd_en) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst.reach_tile2", n < 500, 1'b1);
        rst = 1'b1;
        #1;
        check("rst.outs_now", outs, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst.outs_after", outs, 32'd0);
        run("rerun", 1'b0, cyc);
        check_run("rerun", cyc, 152, 5, '{0, 12, 23, 31, 40, 0, 0, 0},
                  '{5, 4, 1, 2, 3, 0, 0, 0}, 80, 6, 50);

        // 32-column instance: second K=15 tile would end at column 44 > 32
        sel2 = 1'b1;
        load('{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15});
        run("nofit", 1'b0, cyc);
        check_run("nofit", cyc, 44, 1, '{0, 0, 0, 0, 0, 0, 0, 0},
                  '{15, 0, 0, 0, 0, 0, 0, 0}, 16, 2, 22);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
